core_dispatch_unit: RTL

Parametrised successor to the single-issue processor front end. Accepts ALU, load and store commands through a valid/ready port into a DEPTH-entry command FIFO and executes them strictly in order. ALU ops run on an internal datapath; loads and stores go to the cache over a split-bus request/grant interface with bounded miss retry. Each command returns one response pulse carrying a result and an error flag.

---
 rtl/core_dispatch_unit_pkg.sv | 20 ++
 rtl/core_cmd_fifo.sv | 53 +++++
 rtl/core_dispatch_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/core_dispatch_unit_pkg.sv
// Shared types for the dispatch unit: op codes, FSM states and cache bus encodings.
package core_dispatch_unit_pkg;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_XOR, OP_LOAD, OP_STORE, OP_NOP
  } core_op_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_ALU, ST_MEM, ST_RESP
  } core_state_e;

  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_IDLE  = 2'b00;

  function automatic logic is_mem_op(input core_op_e op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/core_cmd_fifo.sv
// Synchronous command FIFO; head is combinational from storage, flags derive from a registered count.
module core_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/core_dispatch_unit.sv
// In-order dispatcher: queued ALU ops complete in 3 cycles; LOAD/STORE wait on cache grants with bounded miss retry.
// Commands backpressure through cmd_ready (FIFO full); responses are single-cycle pulses with no backpressure.
module core_dispatch_unit
  import core_dispatch_unit_pkg::*;
#(
  parameter int DW        = 8,
  parameter int AW        = 12,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  core_op_e        cmd_op,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  output logic            mem_req,
  output logic [1:0]      mem_rw,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_hit,
  input  logic [DW-1:0]   mem_rdata,
  output logic            rsp_valid,
  output core_op_e        rsp_op,
  output logic [2*DW-1:0] rsp_data,
  output logic            rsp_err
);

  localparam int PW  = 3 + 3 * DW + AW;
  localparam int RCW = $clog2(MAX_RETRY + 1);

  logic [PW-1:0] push_data;
  logic [PW-1:0] head;
  logic          full;
  logic          empty;
  logic          pop;
  core_op_e      head_op;

  core_state_e   state_q, state_d;
  core_op_e      op_q;
  logic [DW-1:0] a_q, b_q, wdata_q;
  logic [AW-1:0] addr_q;
  logic [2*DW-1:0] res_q, alu_res;
  logic          err_q;
  logic [RCW-1:0] retry_q, retry_inc;
  logic          retry_last;

  assign push_data = {cmd_op, cmd_a, cmd_b, cmd_addr, cmd_wdata};
  assign cmd_ready = !full;
  assign pop       = (state_q == ST_IDLE) && !empty;
  assign head_op   = core_op_e'(head[PW-1 -: 3]);

  core_cmd_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign retry_inc  = retry_q + RCW'(1);
  assign retry_last = (retry_inc == RCW'(MAX_RETRY));

  // Operands are zero-extended first so SUB yields the true signed difference.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = {{DW{1'b0}}, a_q} + {{DW{1'b0}}, b_q};
      OP_SUB:  alu_res = {{DW{1'b0}}, a_q} - {{DW{1'b0}}, b_q};
      OP_MUL:  alu_res = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
      OP_AND:  alu_res = {{DW{1'b0}}, a_q & b_q};
      OP_XOR:  alu_res = {{DW{1'b0}}, a_q ^ b_q};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!empty) state_d = is_mem_op(head_op) ? ST_MEM : ST_ALU;
      ST_ALU:  state_d = ST_RESP;
      ST_MEM:  if (mem_gnt && (mem_hit || retry_last)) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      if (pop) begin
        op_q    <= head_op;
        a_q     <= head[2*DW+AW +: DW];
        b_q     <= head[DW+AW +: DW];
        addr_q  <= head[DW +: AW];
        wdata_q <= head[DW-1:0];
      end
      case (state_q)
        ST_ALU: begin
          res_q <= alu_res;
          err_q <= 1'b0;
        end
        ST_MEM: begin
          if (mem_gnt && mem_hit) begin
            res_q <= (op_q == OP_LOAD) ? {{DW{1'b0}}, mem_rdata} : '0;
            err_q <= 1'b0;
          end else if (mem_gnt) begin
            retry_q <= retry_inc;
            if (retry_last) begin
              res_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        ST_RESP: retry_q <= '0;
        default: ;
      endcase
    end
  end

  assign mem_req   = (state_q == ST_MEM);
  assign mem_rw    = mem_req ? ((op_q == OP_LOAD) ? RW_READ : RW_WRITE) : RW_IDLE;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_op    = rsp_valid ? op_q : OP_NOP;
  assign rsp_data  = rsp_valid ? res_q : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule
